rgb2y_frame_lock: RTL

// - Upstream stage of the 2D FIR filter: converts HDMI RX RGB888 pixels to 8-bit luma (BT.601 integer weights).
// - Measures active video geometry and forwards video only after one full, consistent frame has been seen.
// - Guarantees the line buffer and systolic FIR always start on a frame boundary.

---
 rtl/rgb2y_frame_lock.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rgb2y_frame_lock.sv
// rgb2y_frame_lock: converts RGB888 to 8-bit BT.601 luma and measures the active video geometry.
// Video is forwarded only while the frame geometry is locked, and forwarding always starts and stops at a vs rise.
module rgb2y_frame_lock #(
   parameter int COEF_R = 77,
   parameter int COEF_G = 150,
   parameter int COEF_B = 29,
   parameter int CNT_W  = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       r_i,
   input  logic [7:0]       g_i,
   input  logic [7:0]       b_i,
   input  logic             dv_i,
   input  logic             hs_i,
   input  logic             vs_i,
   output logic [7:0]       y_o,
   output logic             dv_o,
   output logic             hs_o,
   output logic             vs_o,
   output logic [CNT_W-1:0] h_active_o,
   output logic [CNT_W-1:0] v_active_o,
   output logic             locked_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, MEAS = 2'd1, RUN = 2'd2} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r, next_state_s;
   logic             vs_q_r, dv_q_r;
   logic [CNT_W-1:0] pix_cnt_r, line_cnt_r, first_len_r;
   logic             cons_r;
   logic [CNT_W-1:0] lines_s, first_s;
   logic             cons_s, frame_ok_s, match_s, run_en_s;
   logic             vs_rise_s, dv_fall_s;
   logic [CNT_W-1:0] h_active_r, v_active_r;
   logic             locked_r;
   logic [15:0]      prod_r_r, prod_g_r, prod_b_r;
   logic [16:0]      sum_r;
   logic [2:0]       ctl1_r, ctl2_r, ctl3_r;
   logic [7:0]       y_r;

   assign vs_rise_s = vs_i & ~vs_q_r;
   assign dv_fall_s = dv_q_r & ~dv_i;

   // Frame statistics including a line that ends on this very cycle
   always_comb begin
      lines_s = line_cnt_r;
      first_s = first_len_r;
      cons_s  = cons_r;
      if (dv_fall_s) begin
         if (line_cnt_r != CNT_MAX) begin
            lines_s = line_cnt_r + CNT_ONE;
         end else begin
            lines_s = line_cnt_r;
         end
         if (line_cnt_r == CNT_ZERO) begin
            first_s = pix_cnt_r;
         end else if (pix_cnt_r != first_len_r) begin
            cons_s = 1'b0;
         end else begin
            cons_s = cons_r;
         end
      end else begin
         lines_s = line_cnt_r;
      end
   end

   assign frame_ok_s = cons_s & (lines_s != CNT_ZERO);
   assign match_s    = (first_s == h_active_r) & (lines_s == v_active_r);

   // Next-state logic; transitions happen only on a vs rise
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (vs_rise_s) next_state_s = MEAS;
            else           next_state_s = IDLE;
         end
         MEAS: begin
            if (vs_rise_s && frame_ok_s) next_state_s = RUN;
            else                         next_state_s = MEAS;
         end
         RUN: begin
            if (vs_rise_s && !(frame_ok_s && match_s)) next_state_s = MEAS;
            else                                       next_state_s = RUN;
         end
         default: next_state_s = IDLE;
      endcase
   end

   assign run_en_s = (next_state_s == RUN);

   // Pixel/line measurement counters
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q_r      <= 1'b0;
         dv_q_r      <= 1'b0;
         pix_cnt_r   <= CNT_ZERO;
         line_cnt_r  <= CNT_ZERO;
         first_len_r <= CNT_ZERO;
         cons_r      <= 1'b1;
      end else begin
         vs_q_r <= vs_i;
         dv_q_r <= dv_i;
         if (dv_fall_s)                         pix_cnt_r <= CNT_ZERO;
         else if (dv_i && pix_cnt_r != CNT_MAX) pix_cnt_r <= pix_cnt_r + CNT_ONE;
         if (vs_rise_s) begin
            line_cnt_r  <= CNT_ZERO;
            first_len_r <= CNT_ZERO;
            cons_r      <= 1'b1;
         end else begin
            line_cnt_r  <= lines_s;
            first_len_r <= first_s;
            cons_r      <= cons_s;
         end
      end
   end

   // FSM state, locked geometry and lock flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         h_active_r <= CNT_ZERO;
         v_active_r <= CNT_ZERO;
         locked_r   <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         locked_r <= run_en_s;
         if (vs_rise_s && state_r == MEAS && frame_ok_s) begin
            h_active_r <= first_s;
            v_active_r <= lines_s;
         end
      end
   end

   // Three-stage luma pipeline with gated syncs travelling alongside
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_r_r <= 16'd0;
         prod_g_r <= 16'd0;
         prod_b_r <= 16'd0;
         sum_r    <= 17'd0;
         y_r      <= 8'd0;
         ctl1_r   <= 3'd0;
         ctl2_r   <= 3'd0;
         ctl3_r   <= 3'd0;
      end else begin
         prod_r_r <= 16'(r_i) * 16'(COEF_R);
         prod_g_r <= 16'(g_i) * 16'(COEF_G);
         prod_b_r <= 16'(b_i) * 16'(COEF_B);
         ctl1_r   <= {dv_i & run_en_s, hs_i & run_en_s, vs_i & run_en_s};
         sum_r    <= 17'(prod_r_r) + 17'(prod_g_r) + 17'(prod_b_r) + 17'd128;
         ctl2_r   <= ctl1_r;
         y_r      <= ctl2_r[2] ? sum_r[15:8] : 8'd0;
         ctl3_r   <= ctl2_r;
      end
   end

   assign y_o        = y_r;
   assign dv_o       = ctl3_r[2];
   assign hs_o       = ctl3_r[1];
   assign vs_o       = ctl3_r[0];
   assign h_active_o = h_active_r;
   assign v_active_o = v_active_r;
   assign locked_o   = locked_r;
endmodule
